pfd_chargepump: RTL

- Clocked phase-frequency detector with charge-pump drive for the PLL simulation.
- Compares reference and divided-feedback edges, sampled on an oversampling clock.
- Drives the real-valued charge-pump level into the loop filter's real input.
- Reports signed per-comparison phase error and a lock flag.

---
 rtl/pfd_chargepump.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pfd_chargepump.sv
`default_nettype none
// ============================================================================
// Module   : pfd_chargepump
// Purpose  : Clocked phase-frequency detector with charge-pump drive. Ref and
//            feedback edges are synchronized to an oversampling clock; a
//            three-state FSM (IDLE/UP/DN) measures the edge separation in clk
//            cycles, drives +ICP/-ICP/0 into the loop filter, reports a signed
//            phase error per comparison and raises a lock flag after a run of
//            small errors.
// Revision : 1.0 - initial release
// ============================================================================
module pfd_chargepump #(
  parameter real ICP         = 1.0,
  parameter int  WIDTH_W     = 8,
  parameter int  LOCK_WINDOW = 2,
  parameter int  LOCK_COUNT  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ref_in,
  input  logic                      fb_in,
  output logic                      up,
  output logic                      dn,
  output real                       out,
  output logic signed [WIDTH_W:0]   phase_err,
  output logic                      err_valid,
  output logic                      locked
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  localparam logic [WIDTH_W-1:0] c_WIDTH_MAX   = '1;
  localparam logic [WIDTH_W-1:0] c_WIDTH_ONE   = WIDTH_W'(1);
  localparam logic [GW-1:0]      c_LOCK_COUNT  = GW'(LOCK_COUNT);
  localparam logic [GW-1:0]      c_GOOD_ONE    = GW'(1);
  localparam logic [WIDTH_W:0]   c_LOCK_WINDOW = (WIDTH_W + 1)'(LOCK_WINDOW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DN   = 2'd2
  } state_t;

  // Synchronizer chains: bit0 = s1, bit1 = s2, bit2 = s3 (edge-detect delay)
  logic [2:0]                r_ref_sync;
  logic [2:0]                r_fb_sync;

  state_t                    r_state;
  logic [WIDTH_W-1:0]        r_width;
  logic signed [WIDTH_W:0]   r_phase_err;
  logic                      r_err_valid;
  logic [GW-1:0]             r_good;
  logic                      r_locked;

  state_t                    w_state_nxt;
  logic [WIDTH_W-1:0]        w_width_nxt;
  logic signed [WIDTH_W:0]   w_err_nxt;
  logic                      w_valid_nxt;
  logic                      w_sat;
  logic                      w_ref_rise;
  logic                      w_fb_rise;
  logic signed [WIDTH_W:0]   w_width_ext;
  logic [WIDTH_W:0]          w_err_abs;

  assign w_ref_rise  = r_ref_sync[1] & ~r_ref_sync[2];
  assign w_fb_rise   = r_fb_sync[1]  & ~r_fb_sync[2];
  assign w_width_ext = $signed({1'b0, r_width});
  assign w_err_abs   = w_err_nxt[WIDTH_W] ? -w_err_nxt : w_err_nxt;

  assign up        = (r_state == S_UP);
  assign dn        = (r_state == S_DN);
  assign phase_err = r_phase_err;
  assign err_valid = r_err_valid;
  assign locked    = r_locked;

  // Two-flop synchronizers plus one delay flop per input for rise detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_sync <= '0;
      r_fb_sync  <= '0;
    end else begin
      r_ref_sync <= {r_ref_sync[1:0], ref_in};
      r_fb_sync  <= {r_fb_sync[1:0], fb_in};
    end
  end

  // Next-state / pulse-width / phase-error decode; width saturates and holds
  always_comb begin
    w_state_nxt = r_state;
    w_width_nxt = r_width;
    w_err_nxt   = r_phase_err;
    w_valid_nxt = 1'b0;
    w_sat       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ref_rise && w_fb_rise) begin
          w_err_nxt   = '0;
          w_valid_nxt = 1'b1;
        end else if (w_ref_rise) begin
          w_state_nxt = S_UP;
          w_width_nxt = c_WIDTH_ONE;
        end else if (w_fb_rise) begin
          w_state_nxt = S_DN;
          w_width_nxt = c_WIDTH_ONE;
        end
      end
      S_UP: begin
        if (w_fb_rise) begin
          w_err_nxt   = w_width_ext;
          w_valid_nxt = 1'b1;
          if (w_ref_rise) begin
            w_width_nxt = c_WIDTH_ONE;
          end else begin
            w_state_nxt = S_IDLE;
            w_width_nxt = '0;
          end
        end else begin
          // extra ref edges are ignored here: frequency-detector behaviour
          if (r_width != c_WIDTH_MAX) w_width_nxt = r_width + c_WIDTH_ONE;
          if (r_width >= c_WIDTH_MAX - c_WIDTH_ONE) w_sat = 1'b1;
        end
      end
      S_DN: begin
        if (w_ref_rise) begin
          w_err_nxt   = -w_width_ext;
          w_valid_nxt = 1'b1;
          if (w_fb_rise) begin
            w_width_nxt = c_WIDTH_ONE;
          end else begin
            w_state_nxt = S_IDLE;
            w_width_nxt = '0;
          end
        end else begin
          if (r_width != c_WIDTH_MAX) w_width_nxt = r_width + c_WIDTH_ONE;
          if (r_width >= c_WIDTH_MAX - c_WIDTH_ONE) w_sat = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_width_nxt = '0;
      end
    endcase
  end

  // State, width counter and phase-error report registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_width     <= '0;
      r_phase_err <= '0;
      r_err_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_width     <= w_width_nxt;
      r_phase_err <= w_err_nxt;
      r_err_valid <= w_valid_nxt;
    end
  end

  // Lock detector: counts consecutive small errors, any large error or a
  // saturated pulse drops lock on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_good   <= '0;
      r_locked <= 1'b0;
    end else if (w_sat) begin
      r_good   <= '0;
      r_locked <= 1'b0;
    end else if (w_valid_nxt) begin
      if (w_err_abs <= c_LOCK_WINDOW) begin
        if (r_good != c_LOCK_COUNT) r_good <= r_good + c_GOOD_ONE;
        if (r_good >= c_LOCK_COUNT - c_GOOD_ONE) r_locked <= 1'b1;
      end else begin
        r_good   <= '0;
        r_locked <= 1'b0;
      end
    end
  end

  // Charge-pump level decoded from the state register, piecewise constant
  always_comb begin
    out = 0.0;
    case (r_state)
      S_UP:    out = ICP;
      S_DN:    out = -ICP;
      default: out = 0.0;
    endcase
  end

endmodule
`default_nettype wire
